// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin, burst-limited sharing of one SRAM port between two requesters,
// with registered issue and in-order read return routed back to the issuing requester.
module sram_port_arbiter #(
    parameter int MEM_AWIDTH = 16,
    parameter int RD_LAT     = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [MEM_AWIDTH-1:0] addr0,
    input  logic [MEM_AWIDTH-1:0] addr1,
    input  logic [3:0]            byteen0,
    input  logic [3:0]            byteen1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byteen,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [3:0] MB = 4'(MAX_BURST);

    state_t                  state, state_nx;
    logic [3:0]              burst_cnt, burst_nx;
    logic                    last_owner, last_nx;
    logic                    gnt_any, gnt_id, own, rx, ry, keep;
    logic                    sel_we;
    logic [MEM_AWIDTH-1:0]   sel_addr;
    logic [3:0]              sel_be;
    logic [31:0]             sel_wd;
    logic [RD_LAT:0]         pv, pid;

    assign own  = state == OWN1;
    assign rx   = own ? req1 : req0;
    assign ry   = own ? req0 : req1;
    assign keep = rx && (!ry || burst_cnt < MB);

    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        last_nx  = last_owner;
        gnt_any  = 1'b0;
        gnt_id   = 1'b0;
        if (state == IDLE) begin
            gnt_any  = req0 | req1;
            gnt_id   = !(req0 && (!req1 || last_owner));
            state_nx = gnt_any ? (gnt_id ? OWN1 : OWN0) : IDLE;
            burst_nx = gnt_any ? 4'd1 : burst_cnt;
        end else if (keep) begin
            gnt_any  = 1'b1;
            gnt_id   = own;
            burst_nx = burst_cnt + 4'(burst_cnt != 4'hF);
        end else begin
            gnt_any  = ry;
            gnt_id   = !own;
            last_nx  = own;
            state_nx = ry ? (own ? OWN0 : OWN1) : IDLE;
            burst_nx = ry ? 4'd1 : burst_cnt;
        end
    end

    // Reset forces the combinational grants low so no command is accepted while held.
    assign gnt0     = HRESETN & gnt_any & !gnt_id;
    assign gnt1     = HRESETN & gnt_any & gnt_id;
    assign sel_we   = gnt_id ? we1 : we0;
    assign sel_addr = gnt_id ? addr1 : addr0;
    assign sel_be   = gnt_id ? byteen1 : byteen0;
    assign sel_wd   = gnt_id ? wdata1 : wdata0;
    assign busy     = (state != IDLE) | (|pv);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            pv         <= '0;
            pid        <= '0;
            rdata      <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            state      <= state_nx;
            burst_cnt  <= burst_nx;
            last_owner <= last_nx;
            mem_ren    <= gnt_any & !sel_we;
            mem_wen    <= gnt_any & sel_we;
            if (gnt_any) begin
                mem_addr   <= sel_addr;
                mem_byteen <= sel_we ? sel_be : 4'hF;
                mem_wdata  <= sel_wd;
            end
            pv      <= {pv[RD_LAT-1:0], gnt_any & !sel_we};
            pid     <= {pid[RD_LAT-1:0], gnt_id};
            if (pv[RD_LAT]) rdata <= mem_rdata;
            rvalid0 <= pv[RD_LAT] & !pid[RD_LAT];
            rvalid1 <= pv[RD_LAT] & pid[RD_LAT];
        end
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester arbiter that shares the single fabric SRAM port between requester 0 (AHB-Lite SRAM bridge side) and requester 1 (DMA/readout engine).
- The SRAM port is mem_ren/mem_wen/mem_addr/mem_byteen/mem_wdata/mem_rdata.
- Round-robin selection with a per-tenure burst limit; one access is issued per cycle with no dead cycle on ownership switch.
- Read data is returned to the requester that issued the read, in issue order.

Parameters:
- MEM_AWIDTH, 16, SRAM word-address width.
- RD_LAT, 2, SRAM read latency in cycles from mem_ren to valid mem_rdata. Legal values 1 or 2 (PIPE=0 or PIPE=1).
- MAX_BURST, 4, maximum consecutive grants to one requester while the other requests. Legal range 1..15.

Ports:
- HCLK  in  1  system clock.
- HRESETN  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  access request; command held stable until the matching gnt pulse.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  MEM_AWIDTH  word address.
- byteen0 / byteen1  in  4  write byte enables.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  command accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid, 1-cycle pulse.
- rdata  out  32  registered read data, shared by both requesters.
- busy  out  1  owner FSM not IDLE or a read in flight.
- mem_ren / mem_wen  out  1  SRAM read / write strobe.
- mem_addr  out  MEM_AWIDTH  SRAM address.
- mem_byteen  out  4  SRAM byte enables.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; burst_cnt = 0; last_owner = 1 (requester 0 wins the first tie); read tracking pipe cleared.
- Reset asserted mid-operation: all in-flight reads are discarded and no rvalid is produced for them.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only reqX: grant X, go to OWNX, burst_cnt = 1.
  - Both: grant the requester that is not last_owner.
  - Neither: stay IDLE.
- OWNX:
  - reqX and (!reqY or burst_cnt < MAX_BURST): grant X, burst_cnt++ (saturating at 15).
  - Else if reqY: grant Y in the same cycle, go to OWNY, burst_cnt = 1, last_owner = X.
  - Else: go to IDLE, last_owner = X, no grant.
- gnt0 and gnt1 are mutually exclusive, and gntX is never asserted without reqX.
- Issue: mem_* outputs are registered.
  - Grant in cycle T drives mem_ren (read) or mem_wen (write) high in cycle T+1, for exactly one cycle.
  - mem_addr/mem_byteen/mem_wdata carry the granted command in T+1 and hold their value when idle.
  - mem_byteen = 4'hF for reads.
- Writes: complete at gnt; no response is returned.
- Reads:
  - A tracking shift register of depth RD_LAT+1 carries {valid, id}.
  - mem_rdata is sampled at T+1+RD_LAT into rdata.
  - rvalidID pulses at T+2+RD_LAT. Read-to-rvalid latency from gnt = RD_LAT+2 (4 at default).
  - Back-to-back reads return in issue order, one per cycle; requesters may be interleaved.
- Read and write to the same address in consecutive cycles: SRAM port ordering applies (write issued first is visible to the later read).
- busy = (state != IDLE) | any valid bit in the tracking pipe.

Test Plan:
- Reset release, req0=req1=1 with reads at 0x0010 / 0x0020 -> gnt0 first; mem_ren at T+1 with mem_addr=0x0010; rvalid0 at T+4 with rdata = mem contents.
- req0 held continuously, req1 asserted from cycle 0, MAX_BURST=4 -> gnt0 in 4 consecutive cycles, then gnt1 in the 5th with no gap; mem_ren/mem_wen high every cycle.
- Single req1 write: addr 0x0100, byteen 4'b0011, wdata 0xDEADBEEF -> gnt1 same cycle; next cycle mem_wen=1, mem_addr=0x0100, mem_byteen=4'b0011, mem_wdata=0xDEADBEEF; no rvalid.
- Interleaved reads 0, 1, 0 on consecutive cycles (RD_LAT=1) -> rvalid0, rvalid1, rvalid0 on consecutive cycles starting 3 cycles after the first gnt, each with the correct data.
- Assert HRESETN=0 two cycles after a read grant -> all outputs 0 immediately; no rvalid after reset release; busy=0.
- Both idle after a tenure -> FSM back to IDLE, busy falls RD_LAT+2 cycles after the last read grant; next simultaneous request goes to the non-last owner.
